// File: rtl/logic_pipe.sv
// Bitwise logic unit (AND/OR/XOR/NOR) behind a STAGES-deep valid/ready pipeline.
// The whole pipe freezes when the last stage holds a result the consumer refuses.
module logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [15:0]      count
);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    logic [WIDTH-1:0] data_q  [STAGES];
    logic             zero_q  [STAGES];
    logic             valid_q [STAGES];

    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             stall;

    always_comb begin
        res = '0;
        case (op_e'(op))
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            default: res = '0;
        endcase
        res_zero = (res == '0);
    end

    assign stall    = valid_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    // Bubbles are carried along rather than squeezed out, so a single stall
    // term freezes every stage at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                data_q[i]  <= '0;
                zero_q[i]  <= 1'b0;
                valid_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= res;
                zero_q[0] <= res_zero;
            end
            for (int i = 1; i < STAGES; i++) begin
                data_q[i]  <= data_q[i-1];
                zero_q[i]  <= zero_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'h0000;
        end else if (valid_q[STAGES-1] && out_ready) begin
            count <= count + 16'h0001;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign y         = data_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe: three instances (8b/2st, 1b/1st, 64b/4st)
// sharing operand buses, each with its own handshake signals.
module tb_logic_pipe;

    logic        clk;
    logic        rst;
    logic [63:0] a_bus, b_bus;
    logic [1:0]  op;

    logic        iv8, or8, ov8, ir8, z8;
    logic [7:0]  y8;
    logic [15:0] cnt8;
    logic        iv1, or1, ov1, ir1, z1;
    logic [0:0]  y1;
    logic [15:0] cnt1;
    logic        iv64, or64, ov64, ir64, z64;
    logic [63:0] y64;
    logic [15:0] cnt64;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] exp_y_q [$];
    logic        exp_z_q [$];

    logic_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a_bus[7:0]), .b(b_bus[7:0]),
        .op(op), .out_valid(ov8), .out_ready(or8), .y(y8), .zero(z8), .count(cnt8)
    );
    logic_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a_bus[0:0]), .b(b_bus[0:0]),
        .op(op), .out_valid(ov1), .out_ready(or1), .y(y1), .zero(z1), .count(cnt1)
    );
    logic_pipe #(.WIDTH(64), .STAGES(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a_bus), .b(b_bus),
        .op(op), .out_valid(ov64), .out_ready(or64), .y(y64), .zero(z64), .count(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x,
                                          input logic [63:0] z, input int w);
        logic [63:0] r;
        case (o)
            2'b00:   r = x & z;
            2'b01:   r = x | z;
            2'b10:   r = x ^ z;
            default: r = ~(x | z);
        endcase
        if (w < 64) r = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    function automatic int width_of(input int which);
        return (which == 0) ? 8 : (which == 1) ? 1 : 64;
    endfunction

    function automatic int stages_of(input int which);
        return (which == 0) ? 2 : (which == 1) ? 1 : 4;
    endfunction

    task automatic set_hs(input int which, input logic v, input logic r);
        case (which)
            0:       begin iv8  = v; or8  = r; end
            1:       begin iv1  = v; or1  = r; end
            default: begin iv64 = v; or64 = r; end
        endcase
    endtask

    task automatic sample(input int which, output logic v, output logic [63:0] yy,
                          output logic z, output logic [15:0] c);
        case (which)
            0:       begin v = ov8;  yy = {56'd0, y8}; z = z8;  c = cnt8;  end
            1:       begin v = ov1;  yy = {63'd0, y1}; z = z1;  c = cnt1;  end
            default: begin v = ov64; yy = y64;         z = z64; c = cnt64; end
        endcase
    endtask

    // Back-to-back ops with out_ready high; checks latency, values and idle cycles.
    task automatic run_seq(input string tag, input int which, input logic [63:0] av,
                           input logic [63:0] bv, input logic [1:0] ops [4], input int n);
        int          st;
        int          w;
        int          idx;
        logic        v;
        logic        z;
        logic [63:0] yy;
        logic [63:0] e;
        logic [15:0] c;
        st = stages_of(which);
        w  = width_of(which);
        for (int k = 0; k < n + st + 1; k++) begin
            if (k < n) begin
                a_bus = av;
                b_bus = bv;
                op    = ops[k];
                set_hs(which, 1'b1, 1'b1);
            end else begin
                set_hs(which, 1'b0, 1'b1);
            end
            tick();
            idx = k + 1 - st;
            sample(which, v, yy, z, c);
            if (idx >= 0 && idx < n) begin
                e = model(ops[idx], av, bv, w);
                chk($sformatf("%s_valid%0d", tag, idx), {63'd0, v}, 64'd1);
                chk($sformatf("%s_y%0d", tag, idx), yy, e);
                chk($sformatf("%s_zero%0d", tag, idx), {63'd0, z}, {63'd0, (e == 64'd0)});
            end else begin
                chk($sformatf("%s_idle%0d", tag, k), {63'd0, v}, 64'd0);
            end
        end
        set_hs(which, 1'b0, 1'b1);
    endtask

    initial begin
        logic [1:0]  ops_t [4];
        logic [63:0] e;
        logic [63:0] prev_y;
        logic        ov, ir, zz, acc, prev_stall;
        logic [7:0]  yy;
        int          sent, got, cyc, stall_cycles;

        rst = 1'b0;
        a_bus = '0; b_bus = '0; op = 2'b00;
        iv8 = 0; or8 = 1; iv1 = 0; or1 = 1; iv64 = 0; or64 = 1;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", {63'd0, ov8}, 64'd0);
        chk("rst_in_ready", {63'd0, ir8}, 64'd1);
        chk("rst_count", {48'd0, cnt8}, 64'd0);
        chk("rst_y", {56'd0, y8}, 64'd0);
        chk("rst_zero", {63'd0, z8}, 64'd0);
        chk("rst_out_valid64", {63'd0, ov64}, 64'd0);
        #19 rst = 1'b0;

        // Truth sweep on all three geometries
        ops_t = '{2'd0, 2'd1, 2'd2, 2'd3};
        run_seq("sweep8", 0, 64'hF0, 64'hCC, ops_t, 4);
        chk("sweep8_count", {48'd0, cnt8}, 64'd4);
        run_seq("sweep1", 1, 64'hF0, 64'hCC, ops_t, 4);
        chk("sweep1_count", {48'd0, cnt1}, 64'd4);
        run_seq("sweep64", 2, 64'hF0, 64'hCC, ops_t, 4);
        chk("sweep64_count", {48'd0, cnt64}, 64'd4);
        chk("sweep64_nor_const", y64, 64'hFFFF_FFFF_FFFF_FF03);

        // Zero flag: AND and NOR give 0, OR gives all ones
        ops_t = '{2'd0, 2'd3, 2'd1, 2'd0};
        run_seq("zero8", 0, 64'hAA, 64'h55, ops_t, 3);
        chk("zero8_count", {48'd0, cnt8}, 64'd7);

        // Backpressure: 6 ops, out_ready low for cycles 4..8
        sent = 0; got = 0; cyc = 0; stall_cycles = 0;
        prev_stall = 1'b0; prev_y = '0;
        while (got < 6 && cyc < 60) begin
            or8 = !(cyc >= 4 && cyc < 9);
            iv8 = (sent < 6);
            a_bus = 64'h11 * (sent + 1);
            b_bus = 64'h3C;
            op = 2'(sent % 4);
            #1;
            ov = ov8; ir = ir8; yy = y8; zz = z8;
            if (ov && !or8) begin
                stall_cycles++;
                chk($sformatf("bp_in_ready_c%0d", cyc), {63'd0, ir}, 64'd0);
            end
            if (prev_stall) chk($sformatf("bp_y_hold_c%0d", cyc), {56'd0, yy}, prev_y);
            acc = iv8 && ir;
            if (acc) begin
                e = model(op, a_bus, b_bus, 8);
                exp_y_q.push_back(e);
                exp_z_q.push_back(e == 64'd0);
            end
            if (ov && or8) begin
                if (exp_y_q.size() == 0) begin
                    chk($sformatf("bp_spurious_c%0d", cyc), 64'd1, 64'd0);
                end else begin
                    chk($sformatf("bp_y%0d", got), {56'd0, yy}, exp_y_q.pop_front());
                    chk($sformatf("bp_zero%0d", got), {63'd0, zz}, {63'd0, exp_z_q.pop_front()});
                end
                got++;
            end
            prev_stall = ov && !or8;
            prev_y = {56'd0, yy};
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        iv8 = 1'b0; or8 = 1'b1;
        chk("bp_delivered", 64'(got), 64'd6);
        chk("bp_stall_cycles", 64'(stall_cycles), 64'd5);
        chk("bp_count", {48'd0, cnt8}, 64'd13);

        // Reset with two results in flight
        or8 = 1'b0;
        a_bus = 64'h0F; b_bus = 64'hFF; op = 2'b01; iv8 = 1'b1;
        tick();
        op = 2'b10;
        tick();
        iv8 = 1'b0;
        chk("inflight_valid", {63'd0, ov8}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, ov8}, 64'd0);
        chk("midrst_count", {48'd0, cnt8}, 64'd0);
        chk("midrst_in_ready", {63'd0, ir8}, 64'd1);
        chk("midrst_y", {56'd0, y8}, 64'd0);
        rst = 1'b0;
        ops_t = '{2'd2, 2'd0, 2'd0, 2'd0};
        run_seq("postrst", 0, 64'h5A, 64'h0F, ops_t, 1);
        repeat (3) begin
            tick();
            chk("postrst_no_stale", {63'd0, ov8}, 64'd0);
        end
        chk("postrst_count", {48'd0, cnt8}, 64'd1);

        // Count wrap: 65534 more transfers reach 0xFFFF, one more wraps
        a_bus = 64'h0; b_bus = 64'h0; op = 2'b00;
        iv8 = 1'b1; or8 = 1'b1;
        repeat (65534) tick();
        iv8 = 1'b0;
        repeat (3) tick();
        chk("wrap_ffff", {48'd0, cnt8}, 64'hFFFF);
        ops_t = '{2'd3, 2'd0, 2'd0, 2'd0};
        run_seq("wrap", 0, 64'h00, 64'h01, ops_t, 1);
        chk("wrap_zero", {48'd0, cnt8}, 64'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
